ov7670_pixel_capture: RTL

Front-end capture stage between the OV7670 parallel bus and `qoi_rgb444_encoder`, running entirely in the camera pixel-clock domain. It frame-aligns to `vref`, assembles the two-byte RGB444 pixel stream into 12-bit pixels, and emits per-pixel, per-line and per-frame strobes with line and pixel counts. The encoder and `enc_buff` write addressing consume these strobes directly.

---
 rtl/ov7670_pixel_capture.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB444 capture front end: frame alignment, byte pairing, pixel/line/frame strobes.
// Define CAPTURE_CHECK_EN to build the line-length and frame-length error strobes.
module ov7670_pixel_capture #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        vref,
  input  logic        href,
  input  logic [7:0]  d,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        line_end,
  output logic [9:0]  pix_cnt,
  output logic [8:0]  line_cnt,
  output logic        frame_start,
  output logic        frame_end,
  output logic        busy,
  output logic        err_line,
  output logic        err_frame
);

  typedef enum logic [1:0] {StIdle, StWaitBlank, StWaitFrame, StActive} state_e;

  state_e     state_q;
  logic       phase_q;
  logic       href_q;
  logic [7:0] hi_q;
  logic [9:0] pix_ctr_q;

  logic       line_done;
  logic [9:0] pix_ctr_inc;
  logic [8:0] line_cnt_inc;
  logic       unused_lsbs;

  // A line closes when href falls, or when vref rises while a line is still open.
  assign line_done    = (state_q == StActive) && href_q && (vref || !href);
  assign pix_ctr_inc  = (&pix_ctr_q) ? pix_ctr_q : pix_ctr_q + 10'd1;
  assign line_cnt_inc = (&line_cnt) ? line_cnt : line_cnt + 9'd1;
  assign unused_lsbs  = ^d[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      href_q      <= 1'b0;
      hi_q        <= 8'h00;
      pix_ctr_q   <= 10'd0;
      pix_valid   <= 1'b0;
      pix_rgb     <= 12'h000;
      line_end    <= 1'b0;
      pix_cnt     <= 10'd0;
      line_cnt    <= 9'd0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;

      if (line_done) begin
        line_end  <= 1'b1;
        pix_cnt   <= pix_ctr_q;
        pix_ctr_q <= 10'd0;
        line_cnt  <= line_cnt_inc;
      end

      case (state_q)
        StIdle: begin
          if (capture) begin
            state_q <= StWaitBlank;
            busy    <= 1'b1;
          end
        end
        StWaitBlank: begin
          if (vref) state_q <= StWaitFrame;
        end
        StWaitFrame: begin
          if (!vref) begin
            state_q     <= StActive;
            frame_start <= 1'b1;
            line_cnt    <= 9'd0;
            phase_q     <= 1'b0;
            hi_q        <= 8'h00;
            pix_ctr_q   <= 10'd0;
          end
        end
        StActive: begin
          if (vref) begin
            // The byte sampled on this edge belongs to blanking and is ignored.
            frame_end <= 1'b1;
            phase_q   <= 1'b0;
            href_q    <= 1'b0;
            state_q   <= capture ? StWaitFrame : StIdle;
            busy      <= capture;
          end else begin
            href_q <= href;
            if (href) begin
              phase_q <= ~phase_q;
              if (!phase_q) begin
                hi_q <= d;
              end else begin
                pix_valid <= 1'b1;
                pix_rgb   <= {hi_q, d[7:4]};
                pix_ctr_q <= pix_ctr_inc;
              end
            end else begin
              phase_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAPTURE_CHECK_EN
  logic       err_line_q;
  logic       err_frame_q;
  logic [8:0] frame_lines;

  // A line terminated by vref counts towards the frame being closed.
  assign frame_lines = line_done ? line_cnt_inc : line_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      err_line_q  <= line_done && ((pix_ctr_q != 10'(H_PIXELS)) || phase_q);
      err_frame_q <= (state_q == StActive) && vref && (frame_lines != 9'(V_LINES));
    end
  end

  assign err_line  = err_line_q;
  assign err_frame = err_frame_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{H_PIXELS, V_LINES};
  assign err_line   = 1'b0;
  assign err_frame  = 1'b0;
`endif

endmodule
